// File: rtl/enc_bram_scheduler.sv
// enc_bram_scheduler
// Owns the encrypted-storage BRAM and runs it as a circular buffer. Received
// bytes are XOR-encrypted and written at the write pointer. A valid/ready
// reader drains them in arrival order. The single BRAM port is shared: a
// pending write always takes the port, and the read FSM fetches only when
// the port is free.
// Optional feature: define ENC_BRAM_DECRYPT_ON_READ_EN to hand the reader
// plaintext. By default the reader sees the stored ciphertext. Storage is
// always encrypted.
module enc_bram_scheduler #(
    parameter int         DEPTH   = 16384,
    parameter int         AW      = 14,
    parameter logic [7:0] XOR_KEY = 8'hAA
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_valid,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    state_t        state;
    logic [7:0]    bram [DEPTH];
    logic [7:0]    bram_q;
    logic [7:0]    pend_data;
    logic [7:0]    rd_capture;
    logic          wr_pend;
    logic          commit;
    logic          read_issue;
    logic          rd_take;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] port_addr;

    assign full       = (count == FULL_COUNT);
    assign empty      = (count == '0);
    assign commit     = wr_pend && !full;
    assign read_issue = (state == IDLE) && !wr_pend && !empty;
    assign rd_take    = (state == HOLD) && rd_ready;
    assign port_addr  = wr_pend ? wr_ptr : rd_ptr;

`ifdef ENC_BRAM_DECRYPT_ON_READ_EN
    assign rd_capture = bram_q ^ XOR_KEY;
`else
    assign rd_capture = bram_q;
`endif

    // Single BRAM port: a pending write owns it, otherwise the reader's fetch uses it
    always_ff @(posedge clk) begin
        if (commit) begin
            bram[port_addr] <= pend_data;
        end else if (read_issue) begin
            bram_q <= bram[port_addr];
        end
    end

    // Register each strobe as a ciphertext write that commits in the following cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend   <= 1'b0;
            pend_data <= '0;
        end else begin
            wr_pend <= wr_valid;
            if (wr_valid) begin
                pend_data <= wr_data ^ XOR_KEY;
            end
        end
    end

    // Pointer, occupancy and overflow bookkeeping plus the read FSM with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_pend && full) begin
                overflow <= 1'b1;
            end

            case ({commit, rd_take})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (read_issue) begin
                        state <= READ;
                    end
                end
                READ: begin
                    rd_data  <= rd_capture;
                    rd_valid <= 1'b1;
                    state    <= HOLD;
                end
                HOLD: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_ptr   <= rd_ptr + 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_bram_scheduler.sv
// tb_enc_bram_scheduler
// Self-checking bench for enc_bram_scheduler. A queue-based reference model
// tracks what the buffer holds in arrival order and checks count, flags,
// handshake data and output stability every cycle. Each scenario task also
// checks its own directed expectations. The optional decrypt-on-read build
// (ENC_BRAM_DECRYPT_ON_READ_EN) changes only the byte the reader is expected
// to see. The earlier scenarios leave the pointers at a non-zero offset, so
// the full-buffer fill and drain carry both pointers across the top of the
// address space.
module tb_enc_bram_scheduler;

    localparam int         DEPTH = 16384;
    localparam int         AW    = 14;
    localparam logic [7:0] KEY   = 8'hAA;
`ifdef ENC_BRAM_DECRYPT_ON_READ_EN
    localparam bit DECRYPT = 1'b1;
`else
    localparam bit DECRYPT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  wr_data;
    logic        wr_valid;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [AW:0] count;
    logic        full;
    logic        empty;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         model_pend;
    logic [7:0] model_pend_byte;
    bit         model_ovf;
    bit         prev_stall;
    logic [7:0] prev_data;

    enc_bram_scheduler #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .XOR_KEY (KEY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Byte the reader should receive for a given plaintext byte
    function automatic logic [7:0] reader_view(input logic [7:0] plain);
        return DECRYPT ? plain : (plain ^ KEY);
    endfunction

    // Hard stop in case a scenario stalls beyond its own bounds
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time expired before the summary");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: compare outputs mid-cycle, then apply the coming edge to the model
    always @(negedge clk) begin
        bit full_before;
        if (rst) begin
            exp_q.delete();
            model_pend = 1'b0;
            model_ovf  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            tests_run++;
            if (count !== (AW+1)'(exp_q.size())) begin
                tests_failed++;
                $display("[TB] FAIL model_count: got %0d, expected %0d", count, exp_q.size());
            end
            tests_run++;
            if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
                tests_failed++;
                $display("[TB] FAIL model_flags: got full=%0b empty=%0b, expected occupancy %0d",
                         full, empty, exp_q.size());
            end
            tests_run++;
            if (overflow !== model_ovf) begin
                tests_failed++;
                $display("[TB] FAIL model_overflow: got %0b, expected %0b", overflow, model_ovf);
            end
            if (prev_stall) begin
                tests_run++;
                if (rd_valid !== 1'b1 || rd_data !== prev_data) begin
                    tests_failed++;
                    $display("[TB] FAIL model_hold_stable: got rd_valid=%0b rd_data=%02h, expected 1/%02h",
                             rd_valid, rd_data, prev_data);
                end
            end
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                tests_run++;
                if (exp_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL model_handshake: got rd_data=%02h, expected no byte (buffer empty)", rd_data);
                end else if (rd_data !== exp_q[0]) begin
                    tests_failed++;
                    $display("[TB] FAIL model_order: got rd_data=%02h, expected %02h", rd_data, exp_q[0]);
                end
            end

            prev_stall  = (rd_valid === 1'b1) && (rd_ready !== 1'b1);
            prev_data   = rd_data;
            full_before = (exp_q.size() == DEPTH);
            if (rd_valid === 1'b1 && rd_ready === 1'b1 && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
            end
            if (model_pend) begin
                if (full_before) begin
                    model_ovf = 1'b1;
                end else begin
                    exp_q.push_back(model_pend_byte);
                end
            end
            model_pend      = (wr_valid === 1'b1);
            model_pend_byte = reader_view(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drained(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (count === '0 && rd_valid === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== '0 || empty !== 1'b1 ||
            full !== 1'b0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_initial: got rd_valid=%0b rd_data=%02h count=%0d empty=%0b full=%0b overflow=%0b, expected 0/00/0/1/0/0",
                     rd_valid, rd_data, count, empty, full, overflow);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            wr_valid = 1'b1;
            wr_data  = 8'h10 + 8'(i);
        end
        tick();
        wr_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && count === 15'd5) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL reset_setup: got rd_valid=%0b count=%0d, expected 1/5", rd_valid, count);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b0 || rd_data !== 8'h00 || count !== '0 || empty !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid_hold: got rd_valid=%0b rd_data=%02h count=%0d empty=%0b overflow=%0b, expected 0/00/0/1/0",
                     rd_valid, rd_data, count, empty, overflow);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rd_valid !== 1'b0 || count !== '0 || empty !== 1'b1 || overflow !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_after: got rd_valid=%0b count=%0d empty=%0b overflow=%0b, expected 0/0/1/0",
                     rd_valid, count, empty, overflow);
        end
        tick();
        wr_valid = 1'b1;
        wr_data  = 8'h3C;
        rd_ready = 1'b1;
        tick();
        wr_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok || rd_data !== reader_view(8'h3C)) begin
            tests_failed++;
            $display("[TB] FAIL reset_fresh_data: got rd_valid=%0b rd_data=%02h, expected 1/%02h",
                     rd_valid, rd_data, reader_view(8'h3C));
        end
    endtask

    task automatic test_single_byte();
        bit ok;
        wait_drained(50, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL single_pre_drain: got count=%0d rd_valid=%0b, expected 0/0", count, rd_valid);
        end
        tick();
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 8'h41;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) wr_valid = 1'b0;
            @(negedge clk);
            tests_run++;
            if (c < 4) begin
                if (rd_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL single_early_valid: cycle %0d got rd_valid=%0b, expected 0", c, rd_valid);
                end
            end else if (c == 4) begin
                if (rd_valid !== 1'b1 || rd_data !== reader_view(8'h41)) begin
                    tests_failed++;
                    $display("[TB] FAIL single_latency: cycle 4 got rd_valid=%0b rd_data=%02h, expected 1/%02h",
                             rd_valid, rd_data, reader_view(8'h41));
                end
            end else begin
                if (count !== '0 || rd_valid !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL single_count_return: got count=%0d rd_valid=%0b, expected 0/0", count, rd_valid);
                end
            end
        end
    endtask

    task automatic test_order_backpressure();
        bit ok;
        int n;
        wait_drained(50, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL order_pre_drain: got count=%0d, expected 0", count);
        end
        tick();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h00;
        tick();
        wr_data  = 8'h01;
        tick();
        wr_data  = 8'h02;
        tick();
        wr_valid = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (count !== 15'd3 || rd_valid !== 1'b1 || rd_data !== reader_view(8'h00)) begin
            tests_failed++;
            $display("[TB] FAIL order_backpressure: got count=%0d rd_valid=%0b rd_data=%02h, expected 3/1/%02h",
                     count, rd_valid, rd_data, reader_view(8'h00));
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            tests_run++;
            if (rd_valid !== 1'b1 || rd_data !== reader_view(8'h00) || count !== 15'd3) begin
                tests_failed++;
                $display("[TB] FAIL order_hold_stable: cycle %0d got rd_valid=%0b rd_data=%02h count=%0d, expected 1/%02h/3",
                         c, rd_valid, rd_data, count, reader_view(8'h00));
            end
        end
        tick();
        rd_ready = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 3; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                tests_run++;
                if (rd_data !== reader_view(8'(n))) begin
                    tests_failed++;
                    $display("[TB] FAIL order_sequence: byte %0d got %02h, expected %02h", n, rd_data, reader_view(8'(n)));
                end
                n++;
            end
        end
        tests_run++;
        if (n != 3) begin
            tests_failed++;
            $display("[TB] FAIL order_delivered: got %0d bytes, expected 3", n);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        wait_drained(50, ok);
        tick();
        rd_ready = 1'b0;
        wr_valid = 1'b1;
        wr_data  = 8'h5A;
        tick();
        wr_valid = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok || count !== 15'd1) begin
            tests_failed++;
            $display("[TB] FAIL simul_setup: got rd_valid=%0b count=%0d, expected 1/1", rd_valid, count);
        end
        tick();
        wr_valid = 1'b1;
        wr_data  = 8'hC3;
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (count !== 15'd1 || rd_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL simul_count: got count=%0d rd_valid=%0b, expected 1/0", count, rd_valid);
        end
        ok = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        tests_run++;
        if (!ok || rd_data !== reader_view(8'hC3)) begin
            tests_failed++;
            $display("[TB] FAIL simul_next_byte: got rd_valid=%0b rd_data=%02h, expected 1/%02h within 3 cycles",
                     rd_valid, rd_data, reader_view(8'hC3));
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int c = 0; c < 600; c++) begin
            tick();
            wr_valid = ($urandom_range(0, 9) < 4);
            wr_data  = 8'($urandom);
            rd_ready = ($urandom_range(0, 9) < 7);
        end
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        wait_drained(3000, ok);
        tests_run++;
        if (!ok) begin
            tests_failed++;
            $display("[TB] FAIL random_drain: got count=%0d rd_valid=%0b, expected 0/0", count, rd_valid);
        end
    endtask

    task automatic test_full_overflow();
        logic [7:0] d;
        logic [7:0] last_in;
        logic [7:0] last_out;
        int         n;
        bit         seen_drop;
        tick();
        rd_ready = 1'b0;
        last_in  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            d = 8'($urandom);
            if (d == 8'h55) d = 8'h56;
            wr_valid = 1'b1;
            wr_data  = d;
            last_in  = d;
        end
        tick();
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0 || count !== (AW+1)'(DEPTH)) begin
            tests_failed++;
            $display("[TB] FAIL full_flag: got full=%0b overflow=%0b count=%0d, expected 1/0/%0d",
                     full, overflow, count, DEPTH);
        end
        tick();
        wr_valid = 1'b1;
        wr_data  = 8'h55;
        tick();
        wr_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (overflow !== 1'b1 || full !== 1'b1 || count !== (AW+1)'(DEPTH)) begin
            tests_failed++;
            $display("[TB] FAIL overflow_flag: got overflow=%0b full=%0b count=%0d, expected 1/1/%0d",
                     overflow, full, count, DEPTH);
        end
        tick();
        rd_ready  = 1'b1;
        n         = 0;
        seen_drop = 1'b0;
        last_out  = '0;
        for (int c = 0; c < DEPTH * 3 + 100; c++) begin
            @(negedge clk);
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                if (rd_data === reader_view(8'h55)) seen_drop = 1'b1;
                last_out = rd_data;
                n++;
            end
            if (count === '0 && rd_valid === 1'b0) break;
        end
        tests_run++;
        if (n != DEPTH) begin
            tests_failed++;
            $display("[TB] FAIL drain_count: got %0d bytes, expected %0d", n, DEPTH);
        end
        tests_run++;
        if (last_out !== reader_view(last_in)) begin
            tests_failed++;
            $display("[TB] FAIL drain_last: got %02h, expected %02h", last_out, reader_view(last_in));
        end
        tests_run++;
        if (seen_drop) begin
            tests_failed++;
            $display("[TB] FAIL drop_not_output: got dropped byte %02h on the read side, expected never", reader_view(8'h55));
        end
        tests_run++;
        if (overflow !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL overflow_sticky: got %0b, expected 1", overflow);
        end
    endtask

    task automatic test_wrap_around();
        logic [7:0] local_q[$];
        logic [7:0] d;
        int         sent;
        int         got;
        bit         ok;
        sent = 0;
        got  = 0;
        for (int c = 0; c < 8000 && got < 1000; c++) begin
            tick();
            if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                d        = 8'($urandom);
                wr_valid = 1'b1;
                wr_data  = d;
                local_q.push_back(reader_view(d));
                sent++;
            end else begin
                wr_valid = 1'b0;
            end
            rd_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (rd_valid === 1'b1 && rd_ready === 1'b1) begin
                tests_run++;
                if (local_q.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL wrap_order: got %02h, expected no byte", rd_data);
                end else begin
                    if (rd_data !== local_q[0]) begin
                        tests_failed++;
                        $display("[TB] FAIL wrap_order: byte %0d got %02h, expected %02h", got, rd_data, local_q[0]);
                    end
                    void'(local_q.pop_front());
                end
                got++;
            end
        end
        tick();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        wait_drained(50, ok);
        tests_run++;
        if (!ok || got != 1000 || count !== '0) begin
            tests_failed++;
            $display("[TB] FAIL wrap_end: got %0d bytes count=%0d, expected 1000/0", got, count);
        end
    endtask

    // Scenario sequence and summary
    initial begin
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_ready = 1'b0;
        test_reset();
        test_single_byte();
        test_order_backpressure();
        test_simultaneous();
        test_random();
        test_full_overflow();
        test_wrap_around();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/enc_bram_scheduler.md
# enc_bram_scheduler

Owns the 16384×8 encrypted-storage BRAM and arbitrates its single port between the UART receive path (writer) and a downstream readback consumer (reader). The BRAM is managed as a circular buffer. Every received byte is XOR-encrypted and written at the write pointer. The reader drains bytes in arrival order through a valid/ready handshake. It sits between `uart_receiver` and a future UART-transmit/readback block, replacing the fill-once storage behaviour with continuous store-and-drain.

## Interface
- `DEPTH`, 16384: BRAM entries; power of two.
- `AW`, 14: address width, log2(DEPTH).
- `XOR_KEY`, 8'hAA: encryption key.

- `clk`  in  1: single clock; all logic rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `wr_data`  in  8: plaintext byte from receiver.
- `wr_valid`  in  1: one-cycle strobe; no backpressure; may assert every cycle.
- `rd_data`  out  8: stored byte presented to reader.
- `rd_valid`  out  1: `rd_data` valid; held until accepted.
- `rd_ready`  in  1: reader accepts when `rd_valid && rd_ready`.
- `count`  out  AW+1: occupied entries, 0..DEPTH.
- `full`  out  1: `count == DEPTH`.
- `empty`  out  1: `count == 0`.
- `overflow`  out  1: sticky; a write was dropped because the buffer was full.

## Operation
- **Write capture.**
  - `wr_valid` registers `wr_data ^ XOR_KEY` into a pending register (`wr_pend` set).
  - The pending write commits in the next cycle. It always wins arbitration in that cycle, so `wr_pend` never lasts more than one cycle.
- **Commit.**
  - If not `full`: `bram[wr_ptr] <= pend_data`, `wr_ptr` increments, `count` increments.
  - If `full`: data is dropped, `overflow` is set, and pointers and count are unchanged.
- **Read FSM.**
  - `IDLE`: if `!wr_pend && !empty`, issue a BRAM read at `rd_ptr` and go to `READ`. If `wr_pend`, the write takes the port and the FSM stays in `IDLE`.
  - `READ`: capture synchronous BRAM output into `rd_data`, set `rd_valid`, go to `HOLD`.
  - `HOLD`: hold `rd_data`/`rd_valid` stable. On `rd_ready`, clear `rd_valid`, increment `rd_ptr`, decrement `count`, go to `IDLE`.
- **Port use.** The BRAM port is used only by a commit or by the `IDLE` read issue. Commits proceed freely in `READ` and `HOLD`.
- **Count.**
  - A commit and a read handshake in the same cycle leave `count` unchanged.
  - A dropped write does not change `count`.
- **Pointers.** Both wrap modulo DEPTH, via natural AW-bit rollover.
- **Read/write hazard.** None. Reads only target entries already reflected in `count`, so they never address an entry still pending.
- **Reset mid-operation.** The FSM returns to `IDLE` and any pending write is discarded. BRAM contents are not cleared.

## Timing
- **Reset values:**
  - `rd_data` = 0, `rd_valid` = 0.
  - `count` = 0, `empty` = 1, `full` = 0, `overflow` = 0.
  - `wr_ptr` = `rd_ptr` = 0, state `IDLE`.
- **Write latency.** `wr_valid` in cycle 0 → commit edge at end of cycle 1 → `count`/`empty` updated in cycle 2.
- **Read latency.** Read issue in cycle n (`IDLE`) → `rd_valid` = 1 in cycle n+2.
- **Empty-buffer first byte.** `wr_valid` in cycle 0 → `rd_valid` in cycle 4.
- **Sustained rate.**
  - With `rd_ready` tied high, one byte per 3 cycles when no writes contend.
  - A write pending in `IDLE` delays the read issue by one cycle.
- **Flag timing.** `full`/`empty` are combinational from the registered `count`. `overflow` is set on the drop edge and clears only on `rst`.
- **Handshake rule.** `rd_valid` never deasserts without a handshake, except on `rst`.

## Configuration
- **`ENC_BRAM_DECRYPT_ON_READ_EN` defined:** `rd_data` is captured as `bram_q ^ XOR_KEY`, so the reader sees plaintext.
- **Undefined (default):** `rd_data` = `bram_q`, so the reader sees ciphertext.
- Storage is always encrypted in both cases.

## Test plan
- **Reset.**
  - Assert `rst` mid-`HOLD` with `count` = 5 → `rd_valid` = 0, `count` = 0, `empty` = 1, `overflow` = 0 during and after reset.
  - A subsequent read returns the next written byte, not stale data.
- **Single byte.** `wr_data` = 8'h41 with `rd_ready` = 1 → `rd_valid` in cycle 4.
  - `rd_data` = 8'hEB with the macro undefined.
  - `rd_data` = 8'h41 with the macro defined.
  - `count` returns to 0.
- **Order and backpressure.**
  - Write 8'h00, 8'h01, 8'h02 on consecutive cycles with `rd_ready` = 0 → `count` = 3; `rd_data` = 8'hAA held stable for 20 cycles.
  - Then `rd_ready` = 1 → 8'hAA, 8'hAB, 8'hA8 delivered in order.
- **Full/overflow.**
  - Write 16384 bytes with `rd_ready` = 0 → `full` = 1 and `overflow` = 0.
  - Write 8'h55 → `overflow` = 1 and `count` = 16384.
  - Drain all → 16384 bytes, last = `byte16383 ^ 8'hAA`; 8'h55 is never output.
- **Wrap-around.** Fill 16000, drain 16000, write and drain 1000 more → pointers wrap past 16383; data in order; `count` = 0 at end.
- **Simultaneous events.** `wr_valid` in the same cycle as a `HOLD` handshake at `count` = 1 → `count` stays 1 and the next byte follows within 3 cycles.
